// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: NES sprite DMA sequencer and CPU/DMA address bus arbiter.
// A CPU write to DMA_REG_ADDR halts the CPU and then copies OAM_BYTES bytes
// from CPU page XX00.. into PPU OAM, using alternating read/write cycles.
// Optional feature macro: OAM_DMA_ALIGN_EN. When it is defined, one extra
// ALIGN cycle is inserted whenever the HALT cycle falls on odd parity, which
// matches 2A03 timing. When it is undefined, every transfer takes 1 + 2*OAM_BYTES cycles.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter int          OAM_BYTES    = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_rdy,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        oam_we,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        dma_active
);

  localparam logic [7:0] LAST_IDX = 8'(OAM_BYTES - 1);

`ifdef OAM_DMA_ALIGN_EN
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
`else
  typedef enum logic [2:0] {IDLE, HALT, READ, WRITE} state_t;
`endif

  state_t     state_reg, state_next;
  logic [7:0] page_reg, page_next;
  logic [7:0] idx_reg, idx_next;
  logic       parity_reg;
  logic       active_reg;

`ifndef OAM_DMA_ALIGN_EN
  // Parity is kept as a debug tap even when nothing in the datapath consumes it.
  logic       parity_dbg_unused;
  assign parity_dbg_unused = parity_reg;
`endif

  // Halt/ownership flags are registered from the next state, so they switch
  // on the same edge that enters or leaves IDLE.
  assign dma_active = active_reg;
  assign cpu_rdy    = ~active_reg;

  // State, page/index and parity registers; reset aborts any transfer at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      page_reg   <= 8'h00;
      idx_reg    <= 8'h00;
      parity_reg <= 1'b0;
      active_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      page_reg   <= page_next;
      idx_reg    <= idx_next;
      parity_reg <= ~parity_reg;
      active_reg <= (state_next != IDLE);
    end
  end

  // Next-state logic, bus arbitration and the OAM write port.
  always_comb begin
    state_next = state_reg;
    page_next  = page_reg;
    idx_next   = idx_reg;
    mem_addr   = {page_reg, idx_reg};
    mem_we     = 1'b0;
    mem_wdata  = 8'h00;
    oam_we     = 1'b0;
    oam_addr   = 8'h00;
    oam_wdata  = 8'h00;
    case (state_reg)
      IDLE: begin
        // CPU owns the bus; the trigger write itself also reaches the mapper.
        mem_addr  = cpu_addr;
        mem_we    = cpu_we;
        mem_wdata = cpu_wdata;
        if (cpu_we && (cpu_addr == DMA_REG_ADDR)) begin
          page_next  = cpu_wdata;
          idx_next   = 8'h00;
          state_next = HALT;
        end
      end
      HALT: begin
`ifdef OAM_DMA_ALIGN_EN
        state_next = parity_reg ? ALIGN : READ;
`else
        state_next = READ;
`endif
      end
`ifdef OAM_DMA_ALIGN_EN
      ALIGN: begin
        state_next = READ;
      end
`endif
      READ: begin
        state_next = WRITE;
      end
      WRITE: begin
        // mem_rdata now holds the byte addressed during the preceding READ.
        oam_we    = 1'b1;
        oam_addr  = idx_reg;
        oam_wdata = mem_rdata;
        if (idx_reg == LAST_IDX) begin
          state_next = IDLE;
        end else begin
          idx_next   = idx_reg + 8'd1;
          state_next = READ;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed self-checking bench for oam_dma_ctrl.
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        cpu_rdy;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        oam_we;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        dma_active;

  int checks = 0;
  int failures = 0;
  logic par_m;

`ifdef OAM_DMA_ALIGN_EN
  localparam int ALIGN_ON = 1;
`else
  localparam int ALIGN_ON = 0;
`endif

  oam_dma_ctrl dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata), .cpu_rdy(cpu_rdy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .oam_we(oam_we), .oam_addr(oam_addr), .oam_wdata(oam_wdata), .dma_active(dma_active)
  );

  always #5 clk = ~clk;

  // Memory image: RAM pages hold their low address byte; page FF (ROM) holds its complement.
  function automatic logic [7:0] ram_byte(input logic [15:0] a);
    return (a[15:8] == 8'hFF) ? ~a[7:0] : a[7:0];
  endfunction

  // Mapper model: read data valid one clock after the address.
  always @(posedge clk) mem_rdata <= ram_byte(mem_addr);

  // Reference parity: reset to 0, toggles every clock.
  always @(posedge clk) begin
    if (reset) par_m <= 1'b0;
    else       par_m <= ~par_m;
  end

  // Fires one DMA and observes it to completion; returns raw observations only.
  task automatic do_transfer(input logic [7:0] page, input int want_par, input bit hold_we,
                             output int halt, output int n_oam, output int first_oam,
                             output int bad, output bit trig_par, output bit pass_ok,
                             output bit timeout, output logic [7:0] last_addr);
    logic [15:0] prev_addr;
    int cyc;
    halt = 0; n_oam = 0; first_oam = -1; bad = 0; timeout = 0; last_addr = 8'h00;
    while (want_par >= 0 && par_m !== want_par[0]) @(negedge clk);
    cpu_addr = 16'h4014; cpu_we = 1'b1; cpu_wdata = page; trig_par = par_m;
    #1;
    pass_ok = (mem_addr === 16'h4014) && (mem_we === 1'b1) && (mem_wdata === page) && (cpu_rdy === 1'b1);
    prev_addr = mem_addr;
    @(negedge clk);
    if (hold_we) cpu_wdata = page ^ 8'h05;
    else begin cpu_we = 1'b0; cpu_addr = 16'h1234; end
    cyc = 1;
    forever begin
      #1;
      if (cpu_rdy === 1'b1) break;
      halt++;
      if (dma_active !== 1'b1 || mem_we !== 1'b0) bad++;
      if (oam_we === 1'b1) begin
        if (first_oam < 0) first_oam = cyc;
        if (oam_addr !== n_oam[7:0] || oam_wdata !== ram_byte({page, n_oam[7:0]}) ||
            prev_addr !== {page, n_oam[7:0]}) bad++;
        last_addr = oam_addr;
        n_oam++;
      end
      prev_addr = mem_addr;
      @(negedge clk);
      cyc++;
      if (cyc > 2000) begin timeout = 1; break; end
    end
    cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (cpu_rdy !== 1'b1) begin failures++; $display("FAIL reset_cpu_rdy got=%b exp=1", cpu_rdy); end
    checks++; if (dma_active !== 1'b0) begin failures++; $display("FAIL reset_dma_active got=%b exp=0", dma_active); end
    checks++; if (oam_we !== 1'b0) begin failures++; $display("FAIL reset_oam_we got=%b exp=0", oam_we); end
    checks++; if (oam_addr !== 8'h00) begin failures++; $display("FAIL reset_oam_addr got=%h exp=00", oam_addr); end
    checks++; if (oam_wdata !== 8'h00) begin failures++; $display("FAIL reset_oam_wdata got=%h exp=00", oam_wdata); end
    $display("reset: cpu_rdy=%b dma_active=%b oam_we=%b", cpu_rdy, dma_active, oam_we);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_idle_pass;
    @(negedge clk);
    cpu_addr = 16'h0123; cpu_we = 1'b1; cpu_wdata = 8'h5A;
    #1;
    checks++; if (mem_addr !== 16'h0123) begin failures++; $display("FAIL idle_mem_addr got=%h exp=0123", mem_addr); end
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL idle_mem_we got=%b exp=1", mem_we); end
    checks++; if (mem_wdata !== 8'h5A) begin failures++; $display("FAIL idle_mem_wdata got=%h exp=5a", mem_wdata); end
    checks++; if (cpu_rdy !== 1'b1) begin failures++; $display("FAIL idle_cpu_rdy got=%b exp=1", cpu_rdy); end
    checks++; if (oam_we !== 1'b0) begin failures++; $display("FAIL idle_oam_we got=%b exp=0", oam_we); end
    @(negedge clk);
    #1;
    checks++; if (dma_active !== 1'b0) begin failures++; $display("FAIL idle_no_trigger dma_active got=%b exp=0", dma_active); end
    $display("idle pass-through: mem_addr=%h mem_we=%b mem_wdata=%h", mem_addr, mem_we, mem_wdata);
    cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
  endtask

  task automatic test_basic;
    int halt, n, first, bad; bit tp, ok, to; logic [7:0] last;
    @(negedge clk);
    do_transfer(8'h02, 1, 1'b1, halt, n, first, bad, tp, ok, to, last);
    checks++; if (to) begin failures++; $display("FAIL basic_timeout got=timeout exp=finish"); end
    checks++; if (!ok) begin failures++; $display("FAIL basic_trigger_pass got=0 exp=1"); end
    checks++; if (halt != 513) begin failures++; $display("FAIL basic_halt got=%0d exp=513", halt); end
    checks++; if (n != 256) begin failures++; $display("FAIL basic_oam_count got=%0d exp=256", n); end
    checks++; if (first != 3) begin failures++; $display("FAIL basic_latency got=%0d exp=3", first); end
    checks++; if (bad != 0) begin failures++; $display("FAIL basic_stream_errors got=%0d exp=0", bad); end
    $display("basic dma page 02: halt=%0d oam=%0d first=%0d errors=%0d", halt, n, first, bad);
  endtask

  task automatic test_align;
    int halt, n, first, bad; bit tp, ok, to; logic [7:0] last;
    @(negedge clk);
    do_transfer(8'h03, 0, 1'b0, halt, n, first, bad, tp, ok, to, last);
    checks++; if (to) begin failures++; $display("FAIL align_timeout got=timeout exp=finish"); end
    checks++; if (halt != 513 + ALIGN_ON) begin failures++; $display("FAIL align_halt got=%0d exp=%0d", halt, 513 + ALIGN_ON); end
    checks++; if (first != 3 + ALIGN_ON) begin failures++; $display("FAIL align_latency got=%0d exp=%0d", first, 3 + ALIGN_ON); end
    checks++; if (bad != 0 || n != 256) begin failures++; $display("FAIL align_stream got=%0d errors %0d writes exp=0 errors 256 writes", bad, n); end
    $display("odd-parity dma page 03: halt=%0d first=%0d", halt, first);
  endtask

  task automatic test_page_ff;
    int halt, n, first, bad; bit tp, ok, to; logic [7:0] last;
    @(negedge clk);
    do_transfer(8'hFF, 1, 1'b0, halt, n, first, bad, tp, ok, to, last);
    checks++; if (to) begin failures++; $display("FAIL pageff_timeout got=timeout exp=finish"); end
    checks++; if (n != 256 || bad != 0) begin failures++; $display("FAIL pageff_stream got=%0d writes %0d errors exp=256 writes 0 errors", n, bad); end
    checks++; if (last !== 8'hFF) begin failures++; $display("FAIL pageff_last_oam_addr got=%h exp=ff", last); end
    checks++; if (halt != 513) begin failures++; $display("FAIL pageff_halt got=%0d exp=513", halt); end
    checks++; if (cpu_rdy !== 1'b1 || dma_active !== 1'b0) begin failures++; $display("FAIL pageff_release got=rdy %b act %b exp=rdy 1 act 0", cpu_rdy, dma_active); end
    $display("page ff dma: halt=%0d oam=%0d last_addr=%h", halt, n, last);
  endtask

  task automatic test_back_to_back;
    int halt, n, first, bad, exp_extra; bit tp, ok, to; logic [7:0] last;
    @(negedge clk);
    do_transfer(8'h04, 1, 1'b0, halt, n, first, bad, tp, ok, to, last);
    checks++; if (to || n != 256 || bad != 0) begin failures++; $display("FAIL b2b_first got=%0d writes %0d errors exp=256 writes 0 errors", n, bad); end
    do_transfer(8'h05, -1, 1'b0, halt, n, first, bad, tp, ok, to, last);
    exp_extra = (ALIGN_ON != 0 && tp == 1'b0) ? 1 : 0;
    checks++; if (!ok) begin failures++; $display("FAIL b2b_trigger_pass got=0 exp=1"); end
    checks++; if (to || n != 256 || bad != 0) begin failures++; $display("FAIL b2b_second got=%0d writes %0d errors exp=256 writes 0 errors", n, bad); end
    checks++; if (halt != 513 + exp_extra) begin failures++; $display("FAIL b2b_halt got=%0d exp=%0d", halt, 513 + exp_extra); end
    checks++; if (first != 3 + exp_extra) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", first, 3 + exp_extra); end
    $display("back-to-back second dma page 05: halt=%0d oam=%0d first=%0d", halt, n, first);
  endtask

  task automatic test_reset_midop;
    int n, cyc, extra;
    n = 0; cyc = 0; extra = 0;
    @(negedge clk);
    cpu_addr = 16'h4014; cpu_we = 1'b1; cpu_wdata = 8'h02;
    @(negedge clk);
    cpu_we = 1'b0; cpu_addr = 16'h0000;
    forever begin
      #1;
      if (oam_we === 1'b1) n++;
      if (n == 100) break;
      @(negedge clk);
      cyc++;
      if (cyc > 1000) break;
    end
    checks++; if (n != 100) begin failures++; $display("FAIL midop_reach100 got=%0d exp=100", n); end
    reset = 1'b1; cpu_addr = 16'h0456;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (cpu_rdy !== 1'b1) begin failures++; $display("FAIL midop_cpu_rdy got=%b exp=1", cpu_rdy); end
    checks++; if (dma_active !== 1'b0) begin failures++; $display("FAIL midop_dma_active got=%b exp=0", dma_active); end
    checks++; if (oam_we !== 1'b0) begin failures++; $display("FAIL midop_oam_we got=%b exp=0", oam_we); end
    checks++; if (mem_addr !== 16'h0456) begin failures++; $display("FAIL midop_mem_addr got=%h exp=0456", mem_addr); end
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      #1;
      if (oam_we === 1'b1) extra++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL midop_extra_oam got=%0d exp=0", extra); end
    $display("reset mid-transfer: writes_before=%0d writes_after=%0d", n, extra);
    cpu_addr = 16'h0000;
  endtask

  initial begin
    test_reset;
    test_idle_pass;
    test_basic;
    test_align;
    test_page_ff;
    test_back_to_back;
    test_reset_midop;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
